// File: rtl/UART_MIKE_pkg.sv
// Shared UART uncore definitions: byte width, TX queue depth and the
// TX queue send-FSM state type.
package UART_MIKE_pkg;
  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_TXQ_DEPTH  = 16;

  typedef enum logic [1:0] {
    TXQ_IDLE,
    TXQ_SEND,
    TXQ_WAIT_DONE,
    TXQ_CLEAR
  } uart_txq_state_e;
endpackage

// File: rtl/uart_tx_queue_if.sv
// Byte handshake between the TX queue (master) and the UART core (slave).
interface uart_tx_queue_if
  import UART_MIKE_pkg::*;
#(
  parameter int DATA_W = UART_DATA_WIDTH
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_send;
  logic              tx_flag;
  logic              tx_flag_clr;

  modport master (
    output tx_data,
    output tx_send,
    output tx_flag_clr,
    input  tx_flag
  );

  modport slave (
    input  tx_data,
    input  tx_send,
    input  tx_flag_clr,
    output tx_flag
  );
endinterface

// File: rtl/uart_txq_fifo.sv
// Byte FIFO for the TX queue: synchronous write, registered read-on-pop,
// registered occupancy with full/empty, and a synchronous flush.
module uart_txq_fifo
  import UART_MIKE_pkg::*;
#(
  parameter int DEPTH  = UART_TXQ_DEPTH,
  parameter int DATA_W = UART_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  input  logic                   flush,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  // A flush in the same cycle drops the incoming byte.
  assign push  = wr_en && !full && !flush;
  assign pop   = rd_en && !empty;
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (pop) begin
        rd_data <= mem[rd_ptr];
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: rtl/uart_tx_queue.sv
// MMIO-side UART transmit queue: buffers CPU byte stores and feeds them to the
// UART core one at a time through the send/flag/clear handshake.
module uart_tx_queue
  import UART_MIKE_pkg::*;
#(
  parameter int DEPTH  = UART_TXQ_DEPTH,
  parameter int DATA_W = UART_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   flush,
  input  logic                   ovf_clr,
  uart_tx_queue_if.master        uart,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   busy
);
  uart_txq_state_e   state;
  uart_txq_state_e   state_next;
  logic              pop;
  logic              send;
  logic              flag_clr;
  logic [DATA_W-1:0] head_data;

  uart_txq_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .flush   (flush),
    .rd_data (head_data),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TXQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // IDLE also waits for tx_flag low so a stale flag can never be mistaken
  // for completion of the next byte.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    send       = 1'b0;
    flag_clr   = 1'b0;
    case (state)
      TXQ_IDLE: begin
        if (!empty && !uart.tx_flag) begin
          pop        = 1'b1;
          state_next = TXQ_SEND;
        end
      end
      TXQ_SEND: begin
        send       = 1'b1;
        state_next = TXQ_WAIT_DONE;
      end
      TXQ_WAIT_DONE: begin
        if (uart.tx_flag) begin
          state_next = TXQ_CLEAR;
        end
      end
      TXQ_CLEAR: begin
        flag_clr   = 1'b1;
        state_next = TXQ_IDLE;
      end
      default: state_next = TXQ_IDLE;
    endcase
  end

  // A new drop beats a simultaneous clear; a flushed push is not a drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full && !flush) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  assign uart.tx_data     = head_data;
  assign uart.tx_send     = send;
  assign uart.tx_flag_clr = flag_clr;
  assign busy             = (state != TXQ_IDLE);
endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed scenarios plus randomized traffic, checked
// against a transaction-level queue model and a simple UART flag responder.
module tb_uart_tx_queue;
  import UART_MIKE_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              flush;
  logic              ovf_clr;
  logic [4:0]        count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              busy;

  uart_tx_queue_if #(.DATA_W(DATA_W)) uart ();

  uart_tx_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .ovf_clr  (ovf_clr),
    .uart     (uart),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model: queued bytes, sticky overflow, and one transfer's timeline.
  logic [7:0] q_m[$];
  logic [7:0] sent[$];
  logic [7:0] data_m;
  bit         ovf_m;
  bit         busy_m;
  int         pop_at;
  int         clr_at;
  int         cyc;

  // UART core responder.
  bit uflag;
  bit stall;
  int rise_cnt;
  int fall_cnt;
  int rise_delay;
  int hold_extra;

  int total;
  int bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [7:0] d, input bit f, input bit oc);
    bit fl;
    int occ;
    fl           = uflag | stall;
    uart.tx_flag = fl;
    rst          = r;
    wr_en        = w;
    wr_data      = d;
    flush        = f;
    ovf_clr      = oc;
    @(posedge clk);
    cyc++;
    if (r) begin
      q_m.delete();
      ovf_m  = 0;
      busy_m = 0;
      data_m = 8'h00;
      pop_at = -100;
      clr_at = -100;
    end else begin
      occ = q_m.size();
      if (w && !f && occ == DEPTH) ovf_m = 1;
      else if (oc) ovf_m = 0;
      if (!busy_m) begin
        if (occ > 0 && !fl) begin
          data_m = q_m.pop_front();
          busy_m = 1;
          pop_at = cyc;
          clr_at = -1;
        end
      end else if (clr_at < 0) begin
        if (fl && cyc >= pop_at + 2) clr_at = cyc;
      end else if (cyc == clr_at + 1) begin
        busy_m = 0;
      end
      if (f) q_m.delete();
      else if (w && occ < DEPTH) q_m.push_back(d);
    end
    #1;
    chk("count", count, q_m.size());
    chk("empty", empty, q_m.size() == 0);
    chk("full", full, q_m.size() == DEPTH);
    chk("overflow", overflow, ovf_m);
    chk("busy", busy, busy_m);
    chk("tx_data", uart.tx_data, data_m);
    chk("tx_send", uart.tx_send, busy_m && cyc == pop_at);
    chk("tx_flag_clr", uart.tx_flag_clr, busy_m && cyc == clr_at);
    if (uart.tx_send === 1'b1) sent.push_back(uart.tx_data);
    if (r) begin
      rise_cnt = 0;
      fall_cnt = 0;
    end
    if (uart.tx_send === 1'b1) rise_cnt = rise_delay;
    if (uart.tx_flag_clr === 1'b1) fall_cnt = hold_extra + 2;
    if (rise_cnt > 0) begin
      rise_cnt--;
      if (rise_cnt == 0) uflag = 1;
    end
    if (fall_cnt > 0) begin
      fall_cnt--;
      if (fall_cnt == 0) uflag = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    uflag = 0; stall = 0; rise_cnt = 0; fall_cnt = 0;
    rise_delay = 10; hold_extra = 0;
    uart.tx_flag = 1'b0;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; flush = 1'b0; ovf_clr = 1'b0;

    // Reset values
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);

    // Single byte with the flag raised 10 cycles after tx_send
    sent.delete();
    step(0, 1, 8'h41, 0, 0);
    idle(30);
    chk("t1_sent_n", sent.size(), 1);
    if (sent.size() > 0) chk("t1_byte", sent[0], 8'h41);
    chk("t1_busy_end", busy, 0);

    // Fill while a stale flag blocks draining, overflow, then drain in order
    stall = 1;
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 0);
    chk("t2_full", full, 1);
    step(0, 1, 8'hAA, 0, 0);
    chk("t2_ovf", overflow, 1);
    step(0, 1, 8'h55, 0, 1);
    chk("t2_ovf_set_wins", overflow, 1);
    step(0, 0, 8'h00, 0, 1);
    chk("t2_ovf_cleared", overflow, 0);
    stall = 0;
    rise_delay = 3;
    sent.delete();
    idle(250);
    chk("t2_sent_n", sent.size(), 16);
    for (int i = 0; i < 16 && i < sent.size(); i++) chk("t2_order", sent[i], 32'(i));

    // Flag held 5 extra cycles after clear, 2 bytes waiting
    hold_extra = 5;
    sent.delete();
    step(0, 1, 8'hC1, 0, 0);
    step(0, 1, 8'hC2, 0, 0);
    step(0, 1, 8'hC3, 0, 0);
    idle(80);
    chk("t3_sent_n", sent.size(), 3);
    hold_extra = 0;

    // Flush while the first byte is in flight
    rise_delay = 10;
    sent.delete();
    for (int i = 0; i < 4; i++) step(0, 1, 8'hD0 + 8'(i), 0, 0);
    idle(4);
    step(0, 0, 8'h00, 1, 0);
    idle(30);
    chk("t4_sent_n", sent.size(), 1);
    chk("t4_count", count, 0);

    // Reset mid-transfer, then a stale flag blocks the next send
    step(0, 1, 8'h66, 0, 0);
    idle(5);
    chk("t5_busy_pre", busy, 1);
    step(1, 0, 8'h00, 0, 0);
    chk("t5_send", uart.tx_send, 0);
    chk("t5_clr", uart.tx_flag_clr, 0);
    chk("t5_empty", empty, 1);
    chk("t5_data", uart.tx_data, 0);
    uflag = 1;
    sent.delete();
    step(0, 1, 8'h77, 0, 0);
    idle(5);
    chk("t5_blocked", sent.size(), 0);
    uflag = 0;
    idle(30);
    chk("t5_sent_n", sent.size(), 1);

    // Randomized traffic: light load, then heavy load that overflows
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        rise_delay = int'($urandom_range(1, 12));
        hold_extra = int'($urandom_range(0, 4));
        step(0, ($urandom % 10) < (ph == 0 ? 4 : 9), 8'($urandom),
             ($urandom % 97) == 0, ($urandom % 41) == 0);
      end
    end
    rise_delay = 2;
    hold_extra = 0;
    idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
